// File: rtl/game_sequencer_pkg.sv
// Shared types for the match sequencer: FSM states, mode codes and score width.
// The video encoder decodes the same mode codes.
package game_pkg;

  localparam int unsigned SCORE_W = 6;

  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_TENNIS   = 2'b00;
  localparam logic [1:0] MODE_FOOTBALL = 2'b01;
  localparam logic [1:0] MODE_SQUASH   = 2'b10;
  localparam logic [1:0] MODE_PRACTICE = 2'b11;

  // Scores stop at the all-ones value instead of wrapping.
  function automatic score_t sat_inc(input score_t s);
    return (s == '1) ? s : s + score_t'(1);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Signal bundle between the match sequencer and its surroundings
// (frame timing, buttons, goal-line misses in; encoder/physics controls out).
interface game_sequencer_if;
  import game_pkg::*;

  logic       frame_tick;
  logic       start;
  logic [1:0] mode_sel;
  logic       bat_sel;
  logic       miss_left;
  logic       miss_right;
  logic [1:0] mode;
  logic       bat_size;
  score_t     p1_score;
  score_t     p2_score;
  logic       ball_en;
  logic       ball_load;
  logic       serve_dir;
  logic       game_over;

  modport master (
    output frame_tick, start, mode_sel, bat_sel, miss_left, miss_right,
    input  mode, bat_size, p1_score, p2_score, ball_en, ball_load, serve_dir, game_over
  );

  modport slave (
    input  frame_tick, start, mode_sel, bat_sel, miss_left, miss_right,
    output mode, bat_size, p1_score, p2_score, ball_en, ball_load, serve_dir, game_over
  );
endinterface

// File: rtl/game_sequencer_frame_timer.sv
// 8-bit frame_tick counter with synchronous clear; done pulses on the tick
// that brings the count to term_i.
module frame_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       tick_i,
  input  logic [7:0] term_i,
  output logic       done_o
);
  logic [7:0] cnt_q, cnt_d;

  assign done_o = en_i && tick_i && (({1'b0, cnt_q} + 9'd1) == {1'b0, term_i});

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && tick_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/game_sequencer.sv
// Match-level controller: latches mode/bat size in IDLE, runs the
// serve/play/point/game-over flow, keeps both scores and gates ball motion.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic              clk,
  input  logic              rst_n,
  game_sequencer_if.slave   bus
);
  state_t     state_q, state_d;
  logic       entry_q, entry_d;
  logic [1:0] mode_q, mode_d;
  logic       bat_q, bat_d;
  score_t     p1_q, p1_d, p2_q, p2_d;
  logic       ball_en_q, ball_en_d;
  logic       ball_load_q, ball_load_d;
  logic       serve_dir_q, serve_dir_d;
  logic       game_over_q, game_over_d;

  logic       tmr_en, tmr_clr, tmr_done, win;
  logic [7:0] tmr_term;

  // entry_q masks the first cycle of a state so a tick there is not counted
  assign tmr_en   = ((state_q == ST_SERVE) || (state_q == ST_POINT)) && !entry_q;
  assign tmr_term = (state_q == ST_SERVE) ? 8'(SERVE_FRAMES) : 8'(POINT_FRAMES);
  assign tmr_clr  = (state_d != state_q);
  assign win      = (32'(p1_q) >= WIN_SCORE) || (32'(p2_q) >= WIN_SCORE);

  frame_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .tick_i (bus.frame_tick),
    .term_i (tmr_term),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    bat_d       = bat_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    serve_dir_d = serve_dir_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.frame_tick) begin
          mode_d = bus.mode_sel;
          bat_d  = bus.bat_sel;
        end
        if (bus.start) begin
          state_d     = ST_SERVE;
          p1_d        = '0;
          p2_d        = '0;
          serve_dir_d = 1'b1;
        end
      end
      ST_SERVE: if (tmr_done) state_d = ST_PLAY;
      ST_PLAY: begin
        if (bus.miss_left) begin
          state_d     = ST_POINT;
          serve_dir_d = 1'b1;
          if (mode_q == MODE_PRACTICE) p1_d = sat_inc(p1_q);
          else                         p2_d = sat_inc(p2_q);
        end else if (bus.miss_right &&
                     ((mode_q == MODE_TENNIS) || (mode_q == MODE_FOOTBALL))) begin
          state_d     = ST_POINT;
          serve_dir_d = 1'b0;
          p1_d        = sat_inc(p1_q);
        end
      end
      ST_POINT: if (tmr_done) state_d = win ? ST_OVER : ST_SERVE;
      ST_OVER:  if (bus.start) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    entry_d     = (state_d != state_q);
    ball_en_d   = (state_d == ST_PLAY);
    ball_load_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      entry_q     <= 1'b0;
      mode_q      <= MODE_TENNIS;
      bat_q       <= 1'b0;
      p1_q        <= '0;
      p2_q        <= '0;
      ball_en_q   <= 1'b0;
      ball_load_q <= 1'b0;
      serve_dir_q <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      mode_q      <= mode_d;
      bat_q       <= bat_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      ball_en_q   <= ball_en_d;
      ball_load_q <= ball_load_d;
      serve_dir_q <= serve_dir_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.mode      = mode_q;
  assign bus.bat_size  = bat_q;
  assign bus.p1_score  = p1_q;
  assign bus.p2_score  = p2_q;
  assign bus.ball_en   = ball_en_q;
  assign bus.ball_load = ball_load_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.game_over = game_over_q;
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Match-level controller that sequences the video encoder and the ball physics. It latches game mode and bat size frame-synchronously and runs the serve / play / point / game-over flow. It keeps both 6-bit scores and gates ball motion. Its outputs feed the encoder's mode, bat_size, p1_score and p2_score inputs directly, and the physics block's enable and reload inputs.

Parameters:
WIN_SCORE, 9, score that ends a match (1..63; the encoder renders 0..9 as digits)
SERVE_FRAMES, 60, frame_ticks spent in SERVE before the ball moves (1..255)
POINT_FRAMES, 90, frame_ticks spent in POINT before the next serve or game over (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
frame_tick  in  1  one-cycle pulse at the start of vertical blank
start  in  1  one-cycle pulse from the debounced start button
mode_sel  in  2  requested mode: 00 tennis, 01 football, 10 squash, 11 practice
bat_sel  in  1  requested bat size: 1 large, 0 small
miss_left  in  1  one-cycle pulse when the ball crosses the left goal line
miss_right  in  1  one-cycle pulse when the ball crosses the right goal line
mode  out  2  latched mode to the encoder
bat_size  out  1  latched bat size to the encoder
p1_score  out  6  left score
p2_score  out  6  right score
ball_en  out  1  physics may advance the ball
ball_load  out  1  one-cycle pulse: physics reloads the ball to the centre
serve_dir  out  1  serve direction on reload: 1 rightward, 0 leftward
game_over  out  1  high in OVER

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. All outputs are registered.
- Reset values: mode=00, bat_size=0, scores=0, ball_en=0, ball_load=0, serve_dir=1, game_over=0, state=IDLE, frame counter=0.
- Reset asserted mid-operation returns the block to these values on the next edge. No pending pulse survives reset.
- States are IDLE, SERVE, PLAY, POINT, OVER. Each state transition clears the 8-bit frame counter.
- A frame_tick on the entry cycle of a state is not counted.

State flow:
- IDLE:
  - On each frame_tick, mode<=mode_sel and bat_size<=bat_sel. Outside IDLE, mode and bat_size are frozen, so the encoder never sees a change mid-frame or mid-match.
  - start moves to SERVE. On that edge both scores are cleared and serve_dir<=1. ball_load is high for the first SERVE cycle.
- SERVE:
  - ball_en=0. Counts frame_ticks.
  - On the SERVE_FRAMES-th tick, move to PLAY. ball_en goes high on the first PLAY cycle.
- PLAY (ball_en=1):
  - Modes 00 and 01:
    - miss_left: p2_score+1, serve_dir<=1.
    - miss_right: p1_score+1, serve_dir<=0.
  - Mode 10: miss_left gives p2_score+1, serve_dir<=1. miss_right is ignored (the right side is a wall).
  - Mode 11: miss_left gives p1_score+1 (miss count), serve_dir<=1. miss_right is ignored.
  - A counted miss moves to POINT on the same edge; the score updates on that edge.
  - If both misses arrive in the same cycle, miss_left has priority and only one point is awarded.
  - Misses in any state other than PLAY are ignored.
- POINT:
  - ball_en=0. Counts frame_ticks.
  - On the POINT_FRAMES-th tick:
    - If either score is at least WIN_SCORE, move to OVER.
    - Otherwise move to SERVE, with a ball_load pulse on the first SERVE cycle.
- OVER:
  - game_over=1, ball_en=0, scores held.
  - start moves to IDLE; scores stay displayed until the next match start.
- start is ignored in SERVE, PLAY and POINT.
- Scores saturate at 63 and never wrap.
- ball_load is exactly one cycle wide per SERVE entry.

Decomposition:
- Package game_pkg holds:
  - state encoding constants (IDLE, SERVE, PLAY, POINT, OVER; 3 bits);
  - mode codes MODE_TENNIS=00, MODE_FOOTBALL=01, MODE_SQUASH=10, MODE_PRACTICE=11;
  - the score width (6).
  The video encoder shares these mode codes.
- One natural sub-module, frame_timer. It is an 8-bit frame_tick counter with a synchronous clear and a terminal-count input. It emits a one-cycle done pulse when the count reaches the terminal value. It is instantiated once; SERVE and POINT load different terminal values.

Test Plan:
1. Reset, then mode_sel=01, bat_sel=1, one frame_tick in IDLE -> mode=01, bat_size=1. Change mode_sel to 10 after start -> mode stays 01 for the whole match.
2. start, SERVE_FRAMES=3 -> ball_load high exactly 1 cycle after start. ball_en=0 until the 3rd frame_tick, then 1 on the next cycle. Scores 0/0.
3. Mode 00 in PLAY, miss_right pulse -> p1_score=1, serve_dir=0, POINT. After POINT_FRAMES ticks -> SERVE with a ball_load pulse.
4. Mode 00, miss_left and miss_right asserted in the same cycle -> p2_score+1 only, p1 unchanged, serve_dir=1.
5. Mode 11, WIN_SCORE=2, two miss_left pulses and some miss_right pulses -> p1_score=2, p2_score=0, OVER with game_over=1. start -> IDLE with scores still 2/0. A further start -> scores 0/0.
6. rst_n low for 1 cycle during PLAY with p1_score=5 -> next cycle IDLE, scores 0, ball_en=0, mode=00. A miss_left pulse in the same cycle as reset has no effect.
